// File: rtl/arb_pkg.sv
// Shared encodings and parameter defaults for the unified-memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  localparam int unsigned ADDR_W_DEF     = 8;
  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned MEM_LAT_DEF    = 1;
  localparam int unsigned STARVE_MAX_DEF = 3;

endpackage

// File: rtl/arb_starve_guard.sv
// Fixed data-over-fetch priority with a counter that forces a fetch through
// after STARVE_MAX consecutive contended losses.
module arb_starve_guard
  import arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_strobe,
  input  logic i_req,
  input  logic d_req,
  output logic grant_d
);

  localparam int unsigned CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    grant_d      = d_req && !(i_req && (starve_cnt_q >= CNT_MAX));
    starve_cnt_d = starve_cnt_q;
    if (arb_strobe) begin
      // An uncontended data win leaves the count alone; only contention ages it.
      if (!grant_d) begin
        starve_cnt_d = '0;
      end else if (i_req) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one access
// in flight at a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [LW-1:0]     lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_en_q, mem_en_d;
  logic              i_gnt_q, i_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              i_rvalid_q, i_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic arb_strobe;
  logic grant_d;

  assign arb_strobe = (state_q == IDLE) && (i_req || d_req);

  arb_starve_guard #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_guard (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_strobe(arb_strobe),
    .i_req     (i_req),
    .d_req     (d_req),
    .grant_d   (grant_d)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_cnt_d  = lat_cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    mem_en_d   = 1'b0;
    i_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_strobe) begin
          mem_en_d = 1'b1;
          state_d  = ISSUE;
          if (grant_d) begin
            owner_d = OWN_D;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            d_gnt_d = 1'b1;
          end else begin
            owner_d = OWN_I;
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            i_gnt_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        lat_cnt_d = LAT_INIT;
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_D) begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            i_rdata_d  = mem_rdata;
            i_rvalid_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      lat_cnt_q  <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      mem_en_q   <= 1'b0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lat_cnt_q  <= lat_cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      mem_en_q   <= mem_en_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // The latched write-enable is gated by the ISSUE strobe so mem_we is a single pulse.
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_en_q & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (MEM_LAT 1 and 3) checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int SM   = 3;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]         i_req, i_gnt, i_rvalid, d_req, d_we, d_gnt, d_rvalid, mem_en, mem_we;
  logic [1:0][AW-1:0] i_addr, d_addr, mem_addr;
  logic [1:0][DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT0), .STARVE_MAX(SM)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_gnt(i_gnt[0]), .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1), .STARVE_MAX(SM)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_gnt(i_gnt[1]), .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [DW-1:0] init_word(input int k, input int a);
    if (k == 0 && a == 'h12) return 16'hBEEF;
    return 16'(a * 257 + k * 'h1111 + 'h5A3C);
  endfunction

  // Memory behind each arbiter: read-before-write, data valid MEM_LAT cycles after mem_en.
  logic [DW-1:0] mem  [2][256];
  logic [DW-1:0] pipe [2][4];
  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 256; a++) mem[k][a] = init_word(k, a);
      for (int j = 0; j < 4; j++) pipe[k][j] = '0;
    end
  end
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 3; j > 0; j--) pipe[k][j] <= pipe[k][j-1];
      pipe[k][0] <= mem_en[k] ? mem[k][mem_addr[k]] : 16'hDEAD;
      if (mem_en[k] && mem_we[k]) mem[k][mem_addr[k]] <= mem_wdata[k];
    end
  end
  assign mem_rdata[0] = pipe[0][LAT0-1];
  assign mem_rdata[1] = pipe[1][LAT1-1];

  // Reference model: an access sampled in IDLE lives for MEM_LAT+3 cycles,
  // age 0 = grant/strobe cycle, age MEM_LAT+1 = response cycle.
  bit          m_busy [2];
  int          m_age  [2];
  bit          m_own_d[2];
  bit          m_we   [2];
  bit [AW-1:0] m_addr [2];
  bit [DW-1:0] m_wd   [2];
  bit [DW-1:0] m_rd   [2];
  bit [DW-1:0] m_irdat[2];
  bit [DW-1:0] m_drdat[2];
  int          m_starve[2];
  bit [DW-1:0] m_mem  [2][256];
  initial for (int k = 0; k < 2; k++) for (int a = 0; a < 256; a++) m_mem[k][a] = init_word(k, a);

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] = 0; m_age[k] = 0; m_starve[k] = 0;
        m_irdat[k] = '0; m_drdat[k] = '0; m_addr[k] = '0; m_wd[k] = '0; m_we[k] = 0;
      end else if (!m_busy[k]) begin
        if (i_req[k] || d_req[k]) begin
          bit dwin;
          if (i_req[k] && d_req[k]) begin
            dwin = (m_starve[k] < SM);
            m_starve[k] = dwin ? m_starve[k] + 1 : 0;
          end else begin
            dwin = d_req[k];
            if (!dwin) m_starve[k] = 0;
          end
          m_own_d[k] = dwin;
          m_addr[k]  = dwin ? d_addr[k] : i_addr[k];
          m_we[k]    = dwin && d_we[k];
          m_wd[k]    = d_wdata[k];
          m_busy[k]  = 1;
          m_age[k]   = 0;
        end
      end else if (m_age[k] == lat(k) + 1) begin
        m_busy[k] = 0;
      end else begin
        if (m_age[k] == 0) begin
          m_rd[k] = m_mem[k][m_addr[k]];
          if (m_we[k]) m_mem[k][m_addr[k]] = m_wd[k];
        end
        m_age[k]++;
        if (m_age[k] == lat(k) + 1) begin
          if (m_own_d[k]) m_drdat[k] = m_rd[k];
          else            m_irdat[k] = m_rd[k];
        end
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  int en_cnt[2], gnt_cnt[2], i_evt[2], rv_cnt[2];

  // Per-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit issue, resp;
      issue = m_busy[k] && (m_age[k] == 0);
      resp  = m_busy[k] && (m_age[k] == lat(k) + 1);
      chk($sformatf("mem_en%0d", k),   mem_en[k],   issue);
      chk($sformatf("mem_we%0d", k),   mem_we[k],   issue && m_we[k]);
      chk($sformatf("i_gnt%0d", k),    i_gnt[k],    issue && !m_own_d[k]);
      chk($sformatf("d_gnt%0d", k),    d_gnt[k],    issue && m_own_d[k]);
      chk($sformatf("i_rvalid%0d", k), i_rvalid[k], resp && !m_own_d[k]);
      chk($sformatf("d_rvalid%0d", k), d_rvalid[k], resp && m_own_d[k]);
      chk($sformatf("i_rdata%0d", k),  i_rdata[k],  m_irdat[k]);
      chk($sformatf("d_rdata%0d", k),  d_rdata[k],  m_drdat[k]);
      if (issue) chk($sformatf("mem_addr%0d", k), mem_addr[k], m_addr[k]);
      if (issue && m_we[k]) chk($sformatf("mem_wdata%0d", k), mem_wdata[k], m_wd[k]);
      en_cnt[k]  += int'(mem_en[k]);
      gnt_cnt[k] += int'(i_gnt[k]) + int'(d_gnt[k]);
      i_evt[k]   += int'(i_gnt[k]) + int'(i_rvalid[k]);
      rv_cnt[k]  += int'(i_rvalid[k]) + int'(d_rvalid[k]);
    end
  end

  task automatic req_and_wait(input int k, input bit isd, input bit we, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, output int gcyc);
    if (isd) begin d_req[k] = 1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd; end
    else begin i_req[k] = 1; i_addr[k] = a; end
    gcyc = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (isd ? d_gnt[k] : i_gnt[k]) begin gcyc = cyc; break; end
    end
    if (isd) d_req[k] = 0; else i_req[k] = 0;
    chk("gnt_timeout", 32'(gcyc >= 0), 1);
  endtask

  task automatic contend(input int k, input int n, output logic [7:0] order);
    int ng = 0;
    order = '0;
    i_req[k] = 1; d_req[k] = 1; d_we[k] = 0; i_addr[k] = 8'h30; d_addr[k] = 8'h31;
    for (int c = 0; c < 120 && ng < n; c++) begin
      @(negedge clk);
      if (i_gnt[k] || d_gnt[k]) begin order[ng] = i_gnt[k]; ng++; end
    end
    i_req[k] = 0; d_req[k] = 0;
    chk("contend_count", ng, n);
  endtask

  task automatic drive_random(input bit allow_new);
    for (int k = 0; k < 2; k++) begin
      if (i_req[k] && i_gnt[k]) i_req[k] = 0;
      else if (!i_req[k] && allow_new && $urandom_range(0, 3) == 0) begin
        i_req[k] = 1; i_addr[k] = 8'($urandom_range(0, 31));
      end
      if (d_req[k] && d_gnt[k]) d_req[k] = 0;
      else if (!d_req[k] && allow_new && $urandom_range(0, 2) == 0) begin
        d_req[k] = 1; d_we[k] = 1'($urandom_range(0, 1));
        d_addr[k] = 8'($urandom_range(0, 31)); d_wdata[k] = 16'($urandom);
      end
    end
  endtask

  initial begin
    int t, g, s_en, s_gnt, s_i, s_rv;
    logic [7:0] order;
    i_req = '0; d_req = '0; d_we = '0; i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_mem_en", mem_en, 2'b00);
    chk("reset_rdata", {i_rdata[1], d_rdata[0]}, 32'h0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Single load on the MEM_LAT=1 instance.
    s_i = i_evt[0];
    t = cyc;
    req_and_wait(0, 1, 0, 8'h12, '0, g);
    chk("load_gnt_cycle", g, t + 1);
    chk("load_mem_en", mem_en[0], 1);
    chk("load_mem_addr", mem_addr[0], 8'h12);
    repeat (2) @(negedge clk);
    chk("load_rvalid", d_rvalid[0], 1);
    chk("load_rdata", d_rdata[0], 16'hBEEF);
    repeat (3) @(negedge clk);
    chk("load_no_i_pulse", i_evt[0] - s_i, 0);

    // Store: one-cycle write strobe then completion pulse.
    s_en = en_cnt[0];
    t = cyc;
    req_and_wait(0, 1, 1, 8'h05, 16'h00A5, g);
    chk("store_we", {mem_en[0], mem_we[0]}, 2'b11);
    chk("store_addr", mem_addr[0], 8'h05);
    chk("store_wdata", mem_wdata[0], 16'h00A5);
    @(negedge clk);
    chk("store_en_drop", mem_en[0], 0);
    @(negedge clk);
    chk("store_rvalid", d_rvalid[0], 1);
    repeat (3) @(negedge clk);
    chk("store_en_count", en_cnt[0] - s_en, 1);

    // Continuous contention: D D D I D D D I (bit set = fetch).
    contend(0, 8, order);
    chk("contention_order", order, 8'b1000_1000);
    repeat (6) @(negedge clk);

    // Latency with MEM_LAT=3 and back-to-back spacing.
    t = cyc;
    req_and_wait(1, 0, 0, 8'h40, '0, g);
    chk("lat_i_gnt", g, t + 1);
    d_req[1] = 1; d_we[1] = 0; d_addr[1] = 8'h41;
    repeat (4) @(negedge clk);
    chk("lat_i_rvalid", {i_rvalid[1], d_gnt[1]}, 2'b10);
    g = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (d_gnt[1]) begin g = cyc; break; end
    end
    d_req[1] = 0;
    chk("lat_next_gnt", g, t + 7);
    repeat (8) @(negedge clk);

    // Withdrawn fetch pulse during WAIT is never issued.
    s_en = en_cnt[1]; s_gnt = gnt_cnt[1]; s_i = i_evt[1];
    req_and_wait(1, 1, 0, 8'h22, '0, g);
    @(negedge clk);
    i_req[1] = 1; i_addr[1] = 8'h77;
    @(negedge clk);
    i_req[1] = 0;
    repeat (10) @(negedge clk);
    chk("withdraw_no_i", i_evt[1] - s_i, 0);
    chk("withdraw_en_eq_gnt", en_cnt[1] - s_en, gnt_cnt[1] - s_gnt);

    // Reset during WAIT after building up a starvation count on instance 0.
    contend(0, 2, order);
    chk("prestarve_order", order, 8'b0000_0000);
    repeat (6) @(negedge clk);
    req_and_wait(1, 1, 0, 8'h23, '0, g);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_strobes", {mem_en, mem_we, i_gnt, d_gnt, i_rvalid, d_rvalid}, 12'h0);
    chk("rst_addr_wdata", {mem_addr[1], mem_addr[0], mem_wdata[1]}, 32'h0);
    chk("rst_rdata", {i_rdata[1], d_rdata[1]}, 32'h0);
    s_rv = rv_cnt[1];
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    chk("rst_no_rvalid", rv_cnt[1] - s_rv, 0);
    contend(0, 4, order);
    chk("rst_starve_cleared", order, 8'b0000_1000);
    repeat (6) @(negedge clk);

    // Randomised traffic on both instances, then drain.
    repeat (3000) begin
      @(negedge clk);
      drive_random(1);
    end
    repeat (80) begin
      @(negedge clk);
      drive_random(0);
    end
    chk("drain_idle", {i_req, d_req}, 4'h0);
    chk("final_en_eq_gnt", en_cnt[0] + en_cnt[1], gnt_cnt[0] + gnt_cnt[1]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
